gost_round_ctrl: RTL
====================

GOST_ROUND_CTRL -- requirements
Module: gost_round_ctrl

Interface
REQ-001 The block SHALL have one parameter, ROUND_NUM, default 32, giving the number of Magma rounds per block; only 32 is supported.
REQ-002 iclk  input  1  The block SHALL use this as its single clock; all state changes on the rising edge.
REQ-003 irst_n  input  1  Reset SHALL be asynchronous and active-low.
REQ-004 istart  input  1  Start request; sampled only in the IDLE state.
REQ-005 idecrypt  input  1  Mode select; 0 SHALL mean encrypt and 1 SHALL mean decrypt; sampled together with istart.
REQ-006 ikey  input  256  Cipher key; K0 SHALL be ikey[255:224] and K7 SHALL be ikey[31:0].
REQ-007 iblock  input  64  Input block; sampled together with istart.
REQ-008 oround_start  output  1  One-cycle start pulse to the round stage.
REQ-009 oround_block  output  64  Block presented to the round stage.
REQ-010 oround_key  output  32  Round key presented to the round stage.
REQ-011 iround_block  input  64  Round-stage result, {old low half, new half}.
REQ-012 iround_done  input  1  Round-stage completion pulse.
REQ-013 oblock  output  64  Final cipher result.
REQ-014 odone  output  1  One-cycle completion pulse.
REQ-015 obusy  output  1  Asserted in every state except IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, LAUNCH, WAIT and FINISH.
REQ-017 IDLE with istart=1: the block SHALL latch ikey, idecrypt and iblock into internal registers, clear the 5-bit round counter, and go to LAUNCH.
REQ-018 LAUNCH SHALL assert oround_start for exactly one cycle and then go to WAIT.
REQ-019 WAIT with iround_done=1: the block SHALL capture iround_block as the working block; if the counter equals 31 it SHALL go to FINISH, otherwise it SHALL increment the counter and go to LAUNCH.
REQ-020 WAIT with iround_done=0: the block SHALL stay in WAIT indefinitely (no timeout).
REQ-021 FINISH SHALL drive oblock = {W[31:0], W[63:32]} (final half swap), assert odone for one cycle, and go to IDLE.
REQ-022 oround_block SHALL equal the working block and SHALL stay constant from the LAUNCH cycle through the cycle in which iround_done is seen.
REQ-023 Key index for round i, encrypt: i mod 8 for i<24, and 7-(i mod 8) for i>=24.
REQ-024 Key index for round i, decrypt: i mod 8 for i<8, and 7-(i mod 8) for i>=8.
REQ-025 oround_key SHALL be selected combinationally from the latched key and the counter.
REQ-026 istart outside IDLE, including in the FINISH cycle, SHALL be ignored.
REQ-027 iround_done outside WAIT SHALL be ignored.
REQ-028 Changes to ikey, idecrypt or iblock after acceptance SHALL not affect the operation in progress.
REQ-029 oblock SHALL hold its value until the next FINISH.
REQ-030 Latency with a 3-cycle round stage: istart sampled at cycle 0 SHALL give LAUNCH at cycle 1, 4 cycles per round, and odone at cycle 129.
REQ-031 Back-to-back operation: istart at cycle 130 (IDLE) SHALL be accepted.

Reset
REQ-032 irst_n=0 SHALL immediately force IDLE and clear the counter, the working block, the key register and oblock.
REQ-033 During reset, oround_start, odone and obusy SHALL be 0.
REQ-034 Reset asserted mid-operation SHALL abort the operation with no odone; the next istart after release SHALL start cleanly.

Verification
REQ-035 Encrypt test (bench uses the team's round stage): key ffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, block fedcba9876543210, idecrypt=0 -> odone at cycle 129 with oblock 4ee901e5c2d8ca3d.
REQ-036 Decrypt test: same key, block 4ee901e5c2d8ca3d, idecrypt=1 -> oblock fedcba9876543210.
REQ-037 Key-order test: monitor oround_key over one encrypt and check the 32 indices 0..7,0..7,0..7,7..0; for decrypt check 0..7,7..0,7..0,7..0.
REQ-038 Ignored-input test: istart pulsed during WAIT and during FINISH, and ikey/iblock changed mid-run -> result unchanged and exactly one odone.
REQ-039 Reset test: irst_n low at round 10 -> obusy=0, oblock=0 and no odone; a fresh istart then reproduces REQ-035.
REQ-040 Stall test: round-stage model delays iround_done by 7 cycles -> oround_block is stable throughout and the result is correct.

Source files
------------

// File: rtl/gost_round_ctrl.sv
// Magma (GOST R 34.12-2015) round sequencer: latches a request, drives 32 rounds
// through an external round stage with the key schedule, then applies the final half swap.
module gost_round_ctrl #(
  parameter int ROUND_NUM = 32
) (
  input  logic         iclk,
  input  logic         irst_n,
  input  logic         istart,
  input  logic         idecrypt,
  input  logic [255:0] ikey,
  input  logic [63:0]  iblock,
  output logic         oround_start,
  output logic [63:0]  oround_block,
  output logic [31:0]  oround_key,
  input  logic [63:0]  iround_block,
  input  logic         iround_done,
  output logic [63:0]  oblock,
  output logic         odone,
  output logic         obusy,
  output logic [1:0]   odbg_state
);

  // Handshake: a request is taken when istart=1 while obusy=0; each round is
  // one oround_start pulse answered by one iround_done pulse; odone marks oblock valid.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam logic [4:0] LAST_ROUND = 5'(ROUND_NUM - 1);

  state_t         state_q, state_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [63:0]    blk_q, blk_d;
  logic [255:0]   key_q, key_d;
  logic           dec_q, dec_d;
  logic [63:0]    oblock_q, oblock_d;
  logic           fwd_order;
  logic [2:0]     key_idx;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      blk_q    <= '0;
      key_q    <= '0;
      dec_q    <= 1'b0;
      oblock_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      blk_q    <= blk_d;
      key_q    <= key_d;
      dec_q    <= dec_d;
      oblock_q <= oblock_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    blk_d    = blk_q;
    key_d    = key_q;
    dec_d    = dec_q;
    oblock_d = oblock_q;
    case (state_q)
      ST_IDLE: begin
        if (istart) begin
          key_d   = ikey;
          dec_d   = idecrypt;
          blk_d   = iblock;
          cnt_d   = '0;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (iround_done) begin
          blk_d = iround_block;
          if (cnt_q == LAST_ROUND) begin
            // Result is registered on entry so it is already valid alongside odone.
            oblock_d = {iround_block[31:0], iround_block[63:32]};
            state_d  = ST_FINISH;
          end else begin
            cnt_d   = cnt_q + 5'd1;
            state_d = ST_LAUNCH;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Keys run K0..K7 forward, then K7..K0 for the tail: the last 8 rounds when
  // encrypting, the last 24 when decrypting. 7-i is the bitwise inverse on 3 bits.
  assign fwd_order = dec_q ? (cnt_q < 5'd8) : (cnt_q < 5'd24);
  assign key_idx   = fwd_order ? cnt_q[2:0] : ~cnt_q[2:0];
  assign oround_key = key_q[{~key_idx, 5'b00000} +: 32];

  assign oround_block = blk_q;
  assign oround_start = (state_q == ST_LAUNCH);
  assign odone        = (state_q == ST_FINISH);
  assign obusy        = (state_q != ST_IDLE);
  assign oblock       = oblock_q;
  assign odbg_state   = state_q;

endmodule
